// File: rtl/greater.sv
// greater: registered magnitude comparator with configurable width, signedness
// and latency.
//
// Parameters
//   WIDTH   : operand width, 1..64
//   SIGNED  : 0 = unsigned compare, 1 = two's-complement compare
//   LATENCY : register stages from input sample to visible result, 1..4
//
// Ports
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset, clears every stage
//   in_valid  : a/b are valid and accepted this cycle
//   a, b      : operands
//   out       : registered a > b
//   eq        : registered a == b
//   lt        : registered a < b
//   out_valid : one-cycle pulse per accepted pair; out/eq/lt hold otherwise
//
// The compare is an MSB-first tree: a per-bit (gt, eq) vector is reduced
// pairwise, the higher-order element of each pair taking priority. LATENCY-1
// internal registers are spread across the tree levels; registers that do not
// fit between levels are stacked in front of the output register.
module greater #(
  parameter int WIDTH   = 2,
  parameter int SIGNED  = 0,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out,
  output logic             eq,
  output logic             lt,
  output logic             out_valid
);

  localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 0;
  localparam int INNER  = ((LATENCY - 1) < LEVELS) ? (LATENCY - 1) : LEVELS;
  localparam int EXCESS = LATENCY - 1 - INNER;
  localparam int DIV    = (LEVELS > 0) ? LEVELS : 1;
  // Flipping the sign bit maps two's-complement order onto unsigned order.
  localparam logic [WIDTH-1:0] SIGN_FLIP =
    (SIGNED != 0) ? (WIDTH'(1) << (WIDTH - 1)) : '0;

  // True when a register sits between tree level j and level j+1; spreads
  // INNER registers as evenly as possible over the LEVELS boundaries.
  function automatic bit reg_after(input int j);
    return (((j + 1) * INNER) / DIV) != ((j * INNER) / DIV);
  endfunction

  // One tree level: element j of the result merges elements 2j+1 (higher
  // order, wins) and 2j. An odd leftover passes through; unused slots are 0.
  function automatic logic [2*WIDTH-1:0] reduce_pairs(
    input logic [WIDTH-1:0] gt_in,
    input logic [WIDTH-1:0] eq_in,
    input int               n_in
  );
    logic [WIDTH-1:0] gt_out;
    logic [WIDTH-1:0] eq_out;
    logic [WIDTH:0]   gt_sh;
    logic [WIDTH:0]   eq_sh;
    gt_out = '0;
    eq_out = '0;
    for (int j = 0; j < WIDTH; j++) begin
      gt_sh = {1'b0, gt_in} >> (2 * j);
      eq_sh = {1'b0, eq_in} >> (2 * j);
      if ((2 * j + 1) < n_in) begin
        gt_out[j] = gt_sh[1] | (eq_sh[1] & gt_sh[0]);
        eq_out[j] = eq_sh[1] & eq_sh[0];
      end else if ((2 * j) < n_in) begin
        gt_out[j] = gt_sh[0];
        eq_out[j] = eq_sh[0];
      end else begin
        gt_out[j] = 1'b0;
        eq_out[j] = 1'b0;
      end
    end
    return {gt_out, eq_out};
  endfunction

  logic [WIDTH-1:0] a_m;
  logic [WIDTH-1:0] b_m;
  logic [WIDTH-1:0] comb_gt [LEVELS+1];
  logic [WIDTH-1:0] comb_eq [LEVELS+1];
  logic             comb_v  [LEVELS+1];
  logic [WIDTH-1:0] src_gt  [LEVELS+1];
  logic [WIDTH-1:0] src_eq  [LEVELS+1];
  logic             src_v   [LEVELS+1];

  assign a_m        = a ^ SIGN_FLIP;
  assign b_m        = b ^ SIGN_FLIP;
  assign comb_gt[0] = a_m & ~b_m;
  assign comb_eq[0] = ~(a_m ^ b_m);
  assign comb_v[0]  = in_valid;

  for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
    if ((k < LEVELS) && reg_after(k)) begin : g_reg
      logic [WIDTH-1:0] st_gt_d, st_gt_q, st_eq_d, st_eq_q;
      logic             st_v_d, st_v_q;

      // Only valid operands enter the stage, so idle inputs never propagate.
      always_comb begin
        st_v_d = comb_v[k];
        if (comb_v[k]) begin
          st_gt_d = comb_gt[k];
          st_eq_d = comb_eq[k];
        end else begin
          st_gt_d = st_gt_q;
          st_eq_d = st_eq_q;
        end
      end

      // Pipeline register between tree levels.
      always_ff @(posedge clk) begin
        if (rst) begin
          st_gt_q <= '0;
          st_eq_q <= '0;
          st_v_q  <= 1'b0;
        end else begin
          st_gt_q <= st_gt_d;
          st_eq_q <= st_eq_d;
          st_v_q  <= st_v_d;
        end
      end

      assign src_gt[k] = st_gt_q;
      assign src_eq[k] = st_eq_q;
      assign src_v[k]  = st_v_q;
    end else begin : g_wire
      assign src_gt[k] = comb_gt[k];
      assign src_eq[k] = comb_eq[k];
      assign src_v[k]  = comb_v[k];
    end

    if (k < LEVELS) begin : g_red
      localparam int N_IN = (WIDTH + (1 << k) - 1) >> k;
      assign {comb_gt[k+1], comb_eq[k+1]} = reduce_pairs(src_gt[k], src_eq[k], N_IN);
      assign comb_v[k+1] = src_v[k];
    end
  end

  // The root is element 0; every higher slot is zero by construction.
  logic tree_gt, tree_eq, tree_v;
  logic fin_gt, fin_eq, fin_v;

  assign tree_gt = |src_gt[LEVELS];
  assign tree_eq = |src_eq[LEVELS];
  assign tree_v  = src_v[LEVELS];

  if (EXCESS > 0) begin : g_tail
    logic [EXCESS-1:0] t_gt_d, t_gt_q, t_eq_d, t_eq_q, t_v_d, t_v_q;

    // Shift chain for the registers that did not fit between tree levels.
    always_comb begin
      t_gt_d[0] = tree_gt;
      t_eq_d[0] = tree_eq;
      t_v_d[0]  = tree_v;
      for (int i = 1; i < EXCESS; i++) begin
        t_gt_d[i] = t_gt_q[i-1];
        t_eq_d[i] = t_eq_q[i-1];
        t_v_d[i]  = t_v_q[i-1];
      end
    end

    // Tail pipeline registers.
    always_ff @(posedge clk) begin
      if (rst) begin
        t_gt_q <= '0;
        t_eq_q <= '0;
        t_v_q  <= '0;
      end else begin
        t_gt_q <= t_gt_d;
        t_eq_q <= t_eq_d;
        t_v_q  <= t_v_d;
      end
    end

    assign fin_gt = t_gt_q[EXCESS-1];
    assign fin_eq = t_eq_q[EXCESS-1];
    assign fin_v  = t_v_q[EXCESS-1];
  end else begin : g_no_tail
    assign fin_gt = tree_gt;
    assign fin_eq = tree_eq;
    assign fin_v  = tree_v;
  end

  logic out_d, out_q, eq_d, eq_q, lt_d, lt_q, out_valid_d, out_valid_q;

  // Results update only for a valid pair; otherwise they hold.
  always_comb begin
    out_valid_d = fin_v;
    if (fin_v) begin
      out_d = fin_gt;
      eq_d  = fin_eq;
      lt_d  = ~fin_gt & ~fin_eq;
    end else begin
      out_d = out_q;
      eq_d  = eq_q;
      lt_d  = lt_q;
    end
  end

  // Output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= 1'b0;
      eq_q        <= 1'b0;
      lt_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      eq_q        <= eq_d;
      lt_q        <= lt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign eq        = eq_q;
  assign lt        = lt_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_greater.sv
// tb_greater: several greater instances with different WIDTH/SIGNED/LATENCY
// share one operand bus (each takes the low WIDTH bits). A capture process
// pushes the expected result of every accepted pair into a per-instance queue;
// a monitor pops and compares whenever an instance raises out_valid, and
// checks that out/eq/lt hold between results.
module tb_greater;

  localparam int N = 5;
  localparam int WS [N] = '{2, 2, 8, 1, 13};
  localparam int SS [N] = '{0, 1, 0, 0, 1};
  localparam int LS [N] = '{1, 2, 3, 4, 4};

  typedef struct packed {
    logic [2:0] res;   // {gt, eq, lt}
    int         due;   // edge count after which the result must be visible
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] a;
  logic [63:0] b;

  logic d_out [N];
  logic d_eq  [N];
  logic d_lt  [N];
  logic d_v   [N];

  exp_t       sb [N][$];
  logic [2:0] last [N];
  int         cyc = 0;
  int         rst_cnt = 0;
  int         seen_rst = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    logic o, e, l, v;
    greater #(.WIDTH(WS[g]), .SIGNED(SS[g]), .LATENCY(LS[g])) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .a        (a[WS[g]-1:0]),
      .b        (b[WS[g]-1:0]),
      .out      (o),
      .eq       (e),
      .lt       (l),
      .out_valid(v)
    );
    assign d_out[g] = o;
    assign d_eq[g]  = e;
    assign d_lt[g]  = l;
    assign d_v[g]   = v;
  end

  // Reference: numeric compare of the low w bits, as signed or unsigned values.
  function automatic logic [2:0] ref_cmp(input logic [63:0] x, input logic [63:0] y,
                                         input int w, input int s);
    logic [63:0] mask;
    longint      sx, sy;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    if (s != 0) begin
      sx = longint'(x << (64 - w)) >>> (64 - w);
      sy = longint'(y << (64 - w)) >>> (64 - w);
      return {sx > sy, sx == sy, sx < sy};
    end else begin
      return {(x & mask) > (y & mask), (x & mask) == (y & mask), (x & mask) < (y & mask)};
    end
  endfunction

  // Capture side: record what each instance accepts at this edge.
  always @(posedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    if (rst) rst_cnt = rst_cnt + 1;
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        sb[i].delete();
      end else if (in_valid) begin
        e.res = ref_cmp(a, b, WS[i], SS[i]);
        e.due = cyc + LS[i] - 1;
        sb[i].push_back(e);
      end
    end
  end

  // Monitor: compare on out_valid, otherwise check that results hold.
  always @(negedge clk) begin
    exp_t e;
    logic [2:0] got;
    if (seen_rst != rst_cnt) begin
      seen_rst = rst_cnt;
      for (int i = 0; i < N; i++) last[i] = 3'b000;
    end
    for (int i = 0; i < N; i++) begin
      got = {d_out[i], d_eq[i], d_lt[i]};
      if (d_v[i] === 1'b1) begin
        n_cmp = n_cmp + 1;
        if (sb[i].size() == 0) begin
          n_bad = n_bad + 1;
          $display("FAIL spurious_valid dut%0d cyc=%0d: out_valid=1 got gt/eq/lt=%b, required no result", i, cyc, got);
        end else begin
          e = sb[i].pop_front();
          if (got !== e.res || e.due != cyc) begin
            n_bad = n_bad + 1;
            $display("FAIL result dut%0d cyc=%0d: got gt/eq/lt=%b, required %b at cyc %0d", i, cyc, got, e.res, e.due);
          end
          last[i] = e.res;
        end
      end else begin
        n_cmp = n_cmp + 1;
        if (got !== last[i] || d_v[i] !== 1'b0) begin
          n_bad = n_bad + 1;
          $display("FAIL hold dut%0d cyc=%0d: got gt/eq/lt=%b valid=%b, required %b valid=0", i, cyc, got, d_v[i], last[i]);
        end
        if (sb[i].size() > 0 && sb[i][0].due <= cyc) begin
          n_cmp = n_cmp + 1;
          n_bad = n_bad + 1;
          $display("FAIL missing dut%0d cyc=%0d: got out_valid=0, required result %b due at cyc %0d", i, cyc, sb[i][0].res, sb[i][0].due);
          void'(sb[i].pop_front());
        end
      end
    end
  end

  task automatic drive(input logic r, input logic v, input logic [63:0] x, input logic [63:0] y);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    a        = x;
    b        = y;
  endtask

  initial begin
    logic [63:0] x, y;
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = 64'd0;
    b        = 64'd0;
    for (int i = 0; i < N; i++) last[i] = 3'b000;
    repeat (2) drive(1'b1, 1'b0, 64'd0, 64'd0);

    // All 16 two-bit pairs back-to-back.
    for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 64'(i >> 2), 64'(i & 3));
    // Signed-mode vectors.
    drive(1'b0, 1'b1, 64'd2, 64'd1);
    drive(1'b0, 1'b1, 64'd1, 64'd3);
    drive(1'b0, 1'b1, 64'd3, 64'd3);
    // Streaming throughput.
    drive(1'b0, 1'b1, 64'd200, 64'd100);
    drive(1'b0, 1'b1, 64'd5, 64'd5);
    drive(1'b0, 1'b1, 64'd0, 64'd255);
    // Valid gap with garbage operands in the gap.
    drive(1'b0, 1'b1, 64'd3, 64'd1);
    drive(1'b0, 1'b0, {$urandom, $urandom}, {$urandom, $urandom});
    drive(1'b0, 1'b1, 64'd0, 64'd3);
    // One-bit boundary and all-zero / all-ones.
    drive(1'b0, 1'b1, 64'd1, 64'd0);
    drive(1'b0, 1'b1, 64'd0, 64'd1);
    drive(1'b0, 1'b1, 64'd1, 64'd1);
    drive(1'b0, 1'b1, 64'd0, '1);
    drive(1'b0, 1'b1, '1, 64'd0);
    drive(1'b0, 1'b1, '1, '1);
    drive(1'b0, 1'b1, 64'd0, 64'd0);
    // Reset while compares are in flight, including a pair offered during reset.
    drive(1'b0, 1'b1, 64'd200, 64'd100);
    drive(1'b0, 1'b1, 64'd7, 64'd9);
    drive(1'b1, 1'b1, 64'd9, 64'd7);
    drive(1'b0, 1'b1, 64'd9, 64'd7);
    repeat (5) drive(1'b0, 1'b0, 64'd0, 64'd0);

    // Randomized traffic with occasional resets and forced equal operands.
    for (int n = 0; n < 300; n++) begin
      x = {$urandom, $urandom};
      y = ($urandom_range(0, 3) == 0) ? x : {$urandom, $urandom};
      drive(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, x, y);
    end

    repeat (8) drive(1'b0, 1'b0, 64'd0, 64'd0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
